// File: rtl/siren_tone_detector.sv
// rtl/siren_tone_detector.sv - half-period tone classifier with debounced LOW/HIGH siren detection
module siren_tone_detector #(
    parameter int CW       = 16,
    parameter int LO_HALF  = 28409,
    parameter int HI_HALF  = 14204,
    parameter int TOL      = 512,
    parameter int STABLE_N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tone_in,
    output logic [CW-1:0] half_period,
    output logic          meas_valid,
    output logic [1:0]    tone_class,
    output logic [1:0]    tone_state,
    output logic          siren_active
);

    localparam int RW = $clog2(STABLE_N + 1);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   LO_W    = (CW+1)'(LO_HALF);
    localparam logic [CW:0]   HI_W    = (CW+1)'(HI_HALF);
    localparam logic [CW:0]   TOL_W   = (CW+1)'(TOL);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_N);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOW  = 2'b01;
    localparam logic [1:0] ST_HIGH = 2'b10;

    logic          s1_q, s2_q, s3_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          have_ref_q, have_ref_d;
    logic [RW-1:0] run_q, run_d, run_n;
    logic [CW-1:0] half_q, half_d;
    logic          valid_q, valid_d;
    logic [1:0]    class_q, class_d;
    logic [1:0]    state_q, state_d;
    logic          siren_q, siren_d;

    logic          edge_w;
    logic          meas_w;
    logic          timeout_w;
    logic [1:0]    cls_w;

    // Widened to CW+1 bits so the distance to a nominal never wraps.
    function automatic logic [1:0] classify(input logic [CW-1:0] x);
        logic [CW:0] xe, dlo, dhi;
        xe  = {1'b0, x};
        dlo = (xe >= LO_W) ? (xe - LO_W) : (LO_W - xe);
        dhi = (xe >= HI_W) ? (xe - HI_W) : (HI_W - xe);
        if (x == CNT_MAX)
            classify = ST_IDLE;
        else if (dlo <= TOL_W)
            classify = ST_LOW;
        else if (dhi <= TOL_W)
            classify = ST_HIGH;
        else
            classify = ST_IDLE;
    endfunction

    assign edge_w    = s2_q ^ s3_q;
    assign meas_w    = edge_w && have_ref_q;
    assign cls_w     = classify(cnt_q);
    assign timeout_w = !edge_w && (cnt_d == CNT_MAX);

    always_comb begin
        if (run_q == '0 || cls_w != class_q)
            run_n = RW'(1);
        else if (run_q >= RUN_MAX)
            run_n = RUN_MAX;
        else
            run_n = run_q + 1'b1;
    end

    always_comb begin
        cnt_d      = cnt_q;
        have_ref_d = have_ref_q;
        run_d      = run_q;
        half_d     = half_q;
        valid_d    = meas_w;
        class_d    = class_q;
        state_d    = state_q;
        siren_d    = siren_q;

        if (edge_w)
            cnt_d = {{(CW-1){1'b0}}, 1'b1};
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        if (edge_w)
            have_ref_d = 1'b1;

        if (meas_w) begin
            half_d  = cnt_q;
            class_d = cls_w;
            run_d   = run_n;
            if (run_n >= RUN_MAX) begin
                if (cls_w == ST_IDLE) begin
                    if (state_q != ST_IDLE) begin
                        state_d    = ST_IDLE;
                        siren_d    = 1'b0;
                        have_ref_d = 1'b0;
                        run_d      = '0;
                    end
                end else if (cls_w != state_q) begin
                    if (state_q != ST_IDLE)
                        siren_d = 1'b1;
                    state_d = cls_w;
                end
            end
        end else if (timeout_w) begin
            state_d    = ST_IDLE;
            siren_d    = 1'b0;
            have_ref_d = 1'b0;
            run_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            have_ref_q <= 1'b0;
            run_q      <= '0;
            half_q     <= '0;
            valid_q    <= 1'b0;
            class_q    <= ST_IDLE;
            state_q    <= ST_IDLE;
            siren_q    <= 1'b0;
        end else begin
            s1_q       <= tone_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            have_ref_q <= have_ref_d;
            run_q      <= run_d;
            half_q     <= half_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            state_q    <= state_d;
            siren_q    <= siren_d;
        end
    end

    assign half_period  = half_q;
    assign meas_valid   = valid_q;
    assign tone_class   = class_q;
    assign tone_state   = state_q;
    assign siren_active = siren_q;

endmodule
